reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp.sv | 110 +++++++++++
 tb/tb_reg_file_mp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Two-write / two-read register file with a per-register busy scoreboard.
// Optional hardwired zero register and same-cycle write-to-read bypass.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] Ard1,
    input  logic [ADDR_W-1:0] Ard2,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic [ADDR_W-1:0] Awr,
    input  logic [DATA_W-1:0] Din,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] Awr2,
    input  logic [DATA_W-1:0] Din2,
    input  logic              WrEn2,
    input  logic [ADDR_W-1:0] Ais,
    input  logic              IsEn,
    input  logic              Flush
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr1_ok;
    logic              wr2_ok;

    assign wr1_ok = WrEn  && !(ZR && (Awr  == '0));
    assign wr2_ok = WrEn2 && !(ZR && (Awr2 == '0));

    // Port 2 is assigned last so it wins a same-address collision.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr1_ok) mem[Awr]  <= Din;
            if (wr2_ok) mem[Awr2] <= Din2;
        end
    end

    // Issue is applied after the write clears so a new producer keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (Flush) begin
            busy_nxt = '0;
        end else begin
            if (WrEn)  busy_nxt[Awr]  = 1'b0;
            if (WrEn2) busy_nxt[Awr2] = 1'b0;
            if (IsEn)  busy_nxt[Ais]  = 1'b1;
        end
        if (ZR) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        Dout1 = mem[Ard1];
        Busy1 = busy[Ard1];
        if (BP) begin
            if (WrEn2 && (Awr2 == Ard1)) begin
                Dout1 = Din2;
                Busy1 = 1'b0;
            end else if (WrEn && (Awr == Ard1)) begin
                Dout1 = Din;
                Busy1 = 1'b0;
            end
        end
        if ((ZR && (Ard1 == '0)) || !Rst_n) begin
            Dout1 = '0;
            Busy1 = 1'b0;
        end
    end

    always_comb begin
        Dout2 = mem[Ard2];
        Busy2 = busy[Ard2];
        if (BP) begin
            if (WrEn2 && (Awr2 == Ard2)) begin
                Dout2 = Din2;
                Busy2 = 1'b0;
            end else if (WrEn && (Awr == Ard2)) begin
                Dout2 = Din;
                Busy2 = 1'b0;
            end
        end
        if ((ZR && (Ard2 == '0)) || !Rst_n) begin
            Dout2 = '0;
            Busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: bypass, no-bypass and narrow instances.
module tb_reg_file_mp;

    logic        Clk = 1'b0;
    logic        rst_n;
    always #5 Clk = ~Clk;

    // Shared stimulus for the 32x32 instances (a: BYPASS=1, b: BYPASS=0)
    logic [4:0]  ard1, ard2, awr, awr2, ais;
    logic [31:0] din, din2;
    logic        wren, wren2, isen, flush;
    logic [31:0] a_dout1, a_dout2, b_dout1, b_dout2;
    logic        a_busy1, a_busy2, b_busy1, b_busy2;

    // Narrow instance c: DATA_W=16, ADDR_W=3
    logic [2:0]  c_ard1, c_ard2, c_awr, c_awr2, c_ais;
    logic [15:0] c_din, c_din2, c_dout1, c_dout2;
    logic        c_wren, c_wren2, c_isen, c_flush, c_busy1, c_busy2;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (
        .Clk(Clk), .Rst_n(rst_n), .Ard1(ard1), .Ard2(ard2),
        .Dout1(a_dout1), .Dout2(a_dout2), .Busy1(a_busy1), .Busy2(a_busy2),
        .Awr(awr), .Din(din), .WrEn(wren), .Awr2(awr2), .Din2(din2), .WrEn2(wren2),
        .Ais(ais), .IsEn(isen), .Flush(flush));

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_b (
        .Clk(Clk), .Rst_n(rst_n), .Ard1(ard1), .Ard2(ard2),
        .Dout1(b_dout1), .Dout2(b_dout2), .Busy1(b_busy1), .Busy2(b_busy2),
        .Awr(awr), .Din(din), .WrEn(wren), .Awr2(awr2), .Din2(din2), .WrEn2(wren2),
        .Ais(ais), .IsEn(isen), .Flush(flush));

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_c (
        .Clk(Clk), .Rst_n(rst_n), .Ard1(c_ard1), .Ard2(c_ard2),
        .Dout1(c_dout1), .Dout2(c_dout2), .Busy1(c_busy1), .Busy2(c_busy2),
        .Awr(c_awr), .Din(c_din), .WrEn(c_wren), .Awr2(c_awr2), .Din2(c_din2), .WrEn2(c_wren2),
        .Ais(c_ais), .IsEn(c_isen), .Flush(c_flush));

    typedef struct {
        int          dut;   // 0=a 1=b 2=c
        int          kind;  // 0=Dout1 1=Dout2 2=Busy1 3=Busy2
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic ex(input int dut, input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.dut = dut; e.kind = kind; e.exp = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic exab(input int kind, input logic [31:0] va, input logic [31:0] vb,
                        input string nm);
        ex(0, kind, va, {nm, "_a"});
        ex(1, kind, vb, {nm, "_b"});
    endtask

    function automatic logic [31:0] get_act(input int dut, input int kind);
        logic [31:0] r;
        r = 'x;
        case (dut)
            0: case (kind)
                   0: r = a_dout1;
                   1: r = a_dout2;
                   2: r = {31'b0, a_busy1};
                   default: r = {31'b0, a_busy2};
               endcase
            1: case (kind)
                   0: r = b_dout1;
                   1: r = b_dout2;
                   2: r = {31'b0, b_busy1};
                   default: r = {31'b0, b_busy2};
               endcase
            default: case (kind)
                   0: r = {16'b0, c_dout1};
                   1: r = {16'b0, c_dout2};
                   2: r = {31'b0, c_busy1};
                   default: r = {31'b0, c_busy2};
               endcase
        endcase
        return r;
    endfunction

    // Monitor: every expectation queued during a cycle is checked mid-cycle.
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(negedge Clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                act = get_act(e.dut, e.kind);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ard1 = '0; ard2 = '0; awr = '0; awr2 = '0; ais = '0;
        din = '0; din2 = '0; wren = 0; wren2 = 0; isen = 0; flush = 0;
    endtask

    task automatic cidle();
        c_ard1 = '0; c_ard2 = '0; c_awr = '0; c_awr2 = '0; c_ais = '0;
        c_din = '0; c_din2 = '0; c_wren = 0; c_wren2 = 0; c_isen = 0; c_flush = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cidle();
        #2;
        exab(0, 0, 0, "init_rst_d1");
        exab(2, 0, 0, "init_rst_b1");
        cyc();
        rst_n = 1'b1;

        // Preload every register with all ones and mark it busy
        for (int a = 1; a < 32; a++) begin
            cyc(); idle();
            wren = 1; awr = 5'(a); din = 32'hFFFF_FFFF;
            isen = 1; ais = 5'(a);
        end
        cyc(); idle(); ard1 = 5; ard2 = 31;
        exab(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_d1");
        exab(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_d2");
        exab(2, 1, 1, "pre_b1");
        exab(3, 1, 1, "pre_b2");

        // Reset dropped between edges clears outputs before the next edge
        cyc(); rst_n = 1'b0;
        exab(0, 0, 0, "rst_d1");
        exab(1, 0, 0, "rst_d2");
        exab(2, 0, 0, "rst_b1");
        exab(3, 0, 0, "rst_b2");
        cyc(); rst_n = 1'b1;
        exab(0, 0, 0, "post_rst_d1");
        exab(3, 0, 0, "post_rst_b2");

        // Single write: bypass in the write cycle, stored value afterwards
        cyc(); idle(); wren = 1; awr = 5; din = 32'h1234_5678; ard1 = 5;
        exab(0, 32'h1234_5678, 32'h0, "byp_d1");
        exab(2, 0, 0, "byp_b1");
        cyc(); idle(); ard1 = 5;
        exab(0, 32'h1234_5678, 32'h1234_5678, "wr_d1");

        // Collision: port 2 wins
        cyc(); idle();
        wren = 1; awr = 9; din = 32'hAAAA_AAAA;
        wren2 = 1; awr2 = 9; din2 = 32'h5555_5555;
        ard1 = 9; ard2 = 9;
        exab(0, 32'h5555_5555, 32'h0, "coll_byp_d1");
        exab(1, 32'h5555_5555, 32'h0, "coll_byp_d2");
        cyc(); idle(); ard1 = 9; ard2 = 9;
        exab(0, 32'h5555_5555, 32'h5555_5555, "coll_d1");
        exab(1, 32'h5555_5555, 32'h5555_5555, "coll_d2");

        // Zero register ignores writes and issue
        cyc(); idle();
        wren = 1; awr = 0; din = 32'hDEAD_BEEF; isen = 1; ais = 0;
        ard1 = 0; ard2 = 0;
        exab(0, 0, 0, "zero_cyc_d1");
        exab(2, 0, 0, "zero_cyc_b1");
        cyc(); idle(); ard1 = 0;
        exab(0, 0, 0, "zero_d1");
        exab(2, 0, 0, "zero_b1");

        // Scoreboard: issue, writeback clear, then issue+write same cycle
        cyc(); idle(); isen = 1; ais = 7; ard1 = 7; ard2 = 7;
        exab(2, 0, 0, "iss_cyc_b1");
        cyc(); idle(); ard1 = 7; ard2 = 7;
        exab(2, 1, 1, "iss_b1");
        exab(3, 1, 1, "iss_b2");
        cyc(); idle(); wren2 = 1; awr2 = 7; din2 = 32'h0000_0042; ard1 = 7; ard2 = 7;
        exab(2, 0, 1, "wb_cyc_b1");
        exab(3, 0, 1, "wb_cyc_b2");
        exab(0, 32'h42, 32'h0, "wb_cyc_d1");
        cyc(); idle(); ard1 = 7;
        exab(2, 0, 0, "wb_b1");
        exab(0, 32'h42, 32'h42, "wb_d1");
        cyc(); idle(); isen = 1; ais = 7; wren = 1; awr = 7; din = 32'h77; ard1 = 7;
        exab(2, 0, 0, "setwin_cyc_b1");
        exab(0, 32'h77, 32'h42, "setwin_cyc_d1");
        cyc(); idle(); ard1 = 7;
        exab(2, 1, 1, "setwin_b1");
        exab(0, 32'h77, 32'h77, "setwin_d1");

        // Flush beats a simultaneous issue
        cyc(); idle(); isen = 1; ais = 3;
        cyc(); idle(); isen = 1; ais = 12; ard1 = 3;
        exab(2, 1, 1, "pre_fl_b3");
        cyc(); idle(); flush = 1; isen = 1; ais = 3; ard1 = 3; ard2 = 12;
        exab(2, 1, 1, "fl_cyc_b1");
        exab(3, 1, 1, "fl_cyc_b2");
        cyc(); idle(); ard1 = 3; ard2 = 12;
        exab(2, 0, 0, "fl_b1");
        exab(3, 0, 0, "fl_b2");
        cyc(); idle(); ard1 = 7;
        exab(2, 0, 0, "fl_b7");

        // Narrow instance: same flush scenario with registers 3 and 6
        cyc(); cidle();
        c_isen = 1; c_ais = 3; c_wren2 = 1; c_awr2 = 5; c_din2 = 16'hBEEF; c_ard1 = 5;
        ex(2, 0, 32'hBEEF, "c_byp_d1");
        cyc(); cidle(); c_isen = 1; c_ais = 6; c_ard1 = 3; c_ard2 = 5;
        ex(2, 2, 1, "c_b3");
        ex(2, 1, 32'hBEEF, "c_d2");
        cyc(); cidle(); c_isen = 1; c_ais = 7; c_ard1 = 6;
        ex(2, 2, 1, "c_b6");
        cyc(); cidle(); c_flush = 1; c_isen = 1; c_ais = 3; c_ard1 = 3; c_ard2 = 6;
        ex(2, 2, 1, "c_fl_cyc_b1");
        ex(2, 3, 1, "c_fl_cyc_b2");
        cyc(); cidle(); c_ard1 = 3; c_ard2 = 7;
        ex(2, 2, 0, "c_fl_b1");
        ex(2, 3, 0, "c_fl_b2");

        cyc(); idle(); cidle();
        @(negedge Clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
